waveform_generator: RTL and testbench
=====================================

# waveform_generator

Parametrised multi-mode phase-accumulator oscillator: the next generation of the codebase's triangle generator. It produces sawtooth, triangle, 50 % square or variable-duty pulse samples in unsigned offset-binary at a configurable width. Frequency changes are glitch-free (deferred to the next phase wrap), and the phase can be hard-synced. It sits between the control/register block and the mixer/DAC path, and advances one sample per `sample_en` strobe.

## Interface
- `DATA_WIDTH`, 16, output sample width.
- `ACC_WIDTH`, 24, phase accumulator width; must be ≥ `DATA_WIDTH`+1 and ≥ 8.

- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `sample_en` input 1: advance one sample this cycle.
- `fcw` input ACC_WIDTH: frequency control word (phase increment).
- `fcw_load` input 1: capture `fcw` as pending increment.
- `phase_sync` input 1: force phase to 0.
- `mode` input 2: 0 saw, 1 triangle, 2 square, 3 pulse.
- `duty` input 8: pulse threshold (mode 3 only).
- `amp` input DATA_WIDTH: amplitude. Present only with `WAVE_AMP_SCALE_EN`.
- `wave_out` output DATA_WIDTH: sample.
- `wave_valid` output 1: `wave_out` updated this cycle.
- `wrap` output 1: phase wrapped while producing this sample.

## Operation
- State: `acc`, `fcw_active`, `fcw_pending`, `pending_flag`.
- Reset (`rst_n`=0 at an edge): all state and all outputs go to 0. Reset takes priority over every other input, including mid-run.
- `fcw_load`=1: `fcw_pending` <= `fcw` and `pending_flag` <= 1. A later load before the pending word is applied overwrites it.
- Pending apply (`fcw_active` <= `fcw_pending`, `pending_flag` <= 0) happens at the first of the following:
  - a `sample_en` cycle whose addition carries out of `acc`;
  - any cycle with `phase_sync`=1;
  - any cycle with `fcw_active`=0 (immediate, since a zero increment never wraps).
- `fcw_load` together with `phase_sync`: the new `fcw` is applied directly that cycle.
- `sample_en`=1 and `phase_sync`=0: `acc` <= (`acc` + `fcw_active`) mod 2^ACC_WIDTH.
- `phase_sync`=1: `acc` <= 0 regardless of `sample_en`. The sample emitted that cycle (if `sample_en`) still uses the old `acc`.
- Waveform f(`acc`), N = `DATA_WIDTH`, A = `ACC_WIDTH`:
  - saw: `acc[A-1 -: N]`.
  - triangle: T = `acc[A-2 -: N]`; output T if `acc[A-1]`=0, else ~T.
  - square: all-ones if `acc[A-1]`=0, else 0.
  - pulse: all-ones if `acc[A-1 -: 8]` < `duty`, else 0. `duty`=0 gives constant 0; `duty`=255 is high for 255/256 of the period.
- `mode` and `duty` are sampled on the cycle they are used; changes take effect immediately, not deferred.
- `wrap`=1 for the sample whose accumulation carried out, and only when `phase_sync`=0.

## Timing
- `sample_en` at cycle n: `wave_out` = f(`acc` before increment), with `wave_valid`=1 and `wrap` at cycle n+1. Latency is 1.
- `wave_valid` and `wrap` are single-cycle pulses. `wave_out` holds its value between samples.
- Back-to-back `sample_en` is supported: one sample per cycle.
- After reset the first sample is f(0). The first applied `fcw` takes effect on the next `sample_en`, because `fcw_active`=0 forces immediate apply.

## Configuration
- `WAVE_AMP_SCALE_EN` defined:
  - `amp` port exists.
  - A registered stage computes `wave_out` = (f × `amp`) >> DATA_WIDTH.
  - `wave_valid` and `wrap` are delayed to match; latency is 2.
  - `amp` = all-ones yields f−1 for f>0, and 0 for f=0. `amp`=0 yields 0.
- `WAVE_AMP_SCALE_EN` undefined: no `amp` port, no multiplier, latency 1.

## Test plan
All scenarios use DATA_WIDTH=16, ACC_WIDTH=24, `sample_en` every cycle, no macro unless stated.
- Reset: hold `rst_n`=0 with random inputs -> `wave_out`=0, `wave_valid`=0, `wrap`=0. Release and load `fcw`=0x100000 -> first sample is 0x0000.
- Saw, `fcw`=0x100000 -> 0x0000, 0x1000, …, 0xF000, 0x0000. `wrap`=1 only with 0xF000.
- Triangle, `fcw`=0x200000 -> 0x0000, 0x4000, 0x8000, 0xC000, 0xFFFF, 0xBFFF, 0x7FFF, 0x3FFF, then repeats.
- Deferred frequency: running saw at 0x100000, load 0x200000 when `acc`=0x300000 -> steps of 0x1000 continue through 0xF000, then 0x0000, 0x2000, 0x4000.
- Pulse, `duty`=0x40, `fcw`=0x100000 -> 4 samples of 0xFFFF then 12 of 0x0000 per period. `duty`=0 -> all 0x0000.
- `phase_sync` mid-period with simultaneous `fcw_load` -> current sample uses the old phase; next sample is f(0) at the new rate. Repeat with `WAVE_AMP_SCALE_EN`, `amp`=0x8000 -> saw 0x2000 outputs 0x1000, with latency 2.

Source files
------------

// File: rtl/waveform_generator.sv
// Phase-accumulator oscillator: saw / triangle / square / pulse in offset binary.
// Optional amplitude scaling stage enabled by defining WAVE_AMP_SCALE_EN (adds one cycle of latency).
module waveform_generator #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_en,
    input  logic [ACC_WIDTH-1:0]  fcw,
    input  logic                  fcw_load,
    input  logic                  phase_sync,
    input  logic [1:0]            mode,
    input  logic [7:0]            duty,
`ifdef WAVE_AMP_SCALE_EN
    input  logic [DATA_WIDTH-1:0] amp,
`endif
    output logic [DATA_WIDTH-1:0] wave_out,
    output logic                  wave_valid,
    output logic                  wrap
);

    function automatic logic [DATA_WIDTH-1:0] shape(input logic [ACC_WIDTH-1:0] a,
                                                    input logic [1:0]           m,
                                                    input logic [7:0]           d);
        logic [DATA_WIDTH-1:0] t;
        t = a[ACC_WIDTH-2 -: DATA_WIDTH];
        shape = '0;
        case (m)
            2'd0:    shape = a[ACC_WIDTH-1 -: DATA_WIDTH];
            2'd1:    shape = a[ACC_WIDTH-1] ? ~t : t;
            2'd2:    shape = a[ACC_WIDTH-1] ? '0 : '1;
            default: shape = (a[ACC_WIDTH-1 -: 8] < d) ? '1 : '0;
        endcase
    endfunction

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] fcw_active_q, fcw_active_d;
    logic [ACC_WIDTH-1:0] fcw_pending_q, fcw_pending_d;
    logic                 pending_flag_q, pending_flag_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 apply;

    logic [DATA_WIDTH-1:0] wave_p1_q;
    logic                  vld_p1_q;
    logic                  wrap_p1_q;

    assign sum   = {1'b0, acc_q} + {1'b0, fcw_active_q};
    assign carry = sample_en & sum[ACC_WIDTH];
    // A zero increment can never wrap, so a pending word is taken at once.
    assign apply = pending_flag_q & (carry | phase_sync | (fcw_active_q == '0));

    always_comb begin
        acc_d          = acc_q;
        fcw_active_d   = fcw_active_q;
        fcw_pending_d  = fcw_pending_q;
        pending_flag_d = pending_flag_q;
        if (fcw_load && phase_sync) begin
            fcw_active_d   = fcw;
            pending_flag_d = 1'b0;
        end else begin
            if (apply) begin
                fcw_active_d   = fcw_pending_q;
                pending_flag_d = 1'b0;
            end
            if (fcw_load) begin
                fcw_pending_d  = fcw;
                pending_flag_d = 1'b1;
            end
        end
        if (phase_sync)
            acc_d = '0;
        else if (sample_en)
            acc_d = sum[ACC_WIDTH-1:0];
    end

    // stage 1: sample the waveform from the pre-increment phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q          <= '0;
            fcw_active_q   <= '0;
            fcw_pending_q  <= '0;
            pending_flag_q <= 1'b0;
            wave_p1_q      <= '0;
            vld_p1_q       <= 1'b0;
            wrap_p1_q      <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            fcw_active_q   <= fcw_active_d;
            fcw_pending_q  <= fcw_pending_d;
            pending_flag_q <= pending_flag_d;
            vld_p1_q       <= sample_en;
            wrap_p1_q      <= carry & ~phase_sync;
            if (sample_en)
                wave_p1_q <= shape(acc_q, mode, duty);
        end
    end

`ifdef WAVE_AMP_SCALE_EN
    function automatic logic [DATA_WIDTH-1:0] scale(input logic [DATA_WIDTH-1:0] f,
                                                    input logic [DATA_WIDTH-1:0] a);
        logic [2*DATA_WIDTH-1:0] p;
        p = {{DATA_WIDTH{1'b0}}, f} * {{DATA_WIDTH{1'b0}}, a};
        return p[2*DATA_WIDTH-1 -: DATA_WIDTH];
    endfunction

    logic [DATA_WIDTH-1:0] wave_p2_q;
    logic                  vld_p2_q;
    logic                  wrap_p2_q;

    // stage 2: amplitude scaling, truncating toward zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wave_p2_q <= '0;
            vld_p2_q  <= 1'b0;
            wrap_p2_q <= 1'b0;
        end else begin
            vld_p2_q  <= vld_p1_q;
            wrap_p2_q <= wrap_p1_q;
            if (vld_p1_q)
                wave_p2_q <= scale(wave_p1_q, amp);
        end
    end

    assign wave_out   = wave_p2_q;
    assign wave_valid = vld_p2_q;
    assign wrap       = wrap_p2_q;
`else
    assign wave_out   = wave_p1_q;
    assign wave_valid = vld_p1_q;
    assign wrap       = wrap_p1_q;
`endif

endmodule

// File: tb/tb_waveform_generator.sv
// Directed bench for waveform_generator; builds with or without WAVE_AMP_SCALE_EN.
module tb_waveform_generator;

`ifdef WAVE_AMP_SCALE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic [23:0] fcw;
    logic        fcw_load;
    logic        phase_sync;
    logic [1:0]  mode;
    logic [7:0]  duty;
`ifdef WAVE_AMP_SCALE_EN
    logic [15:0] amp;
`endif
    logic [15:0] wave_out;
    logic        wave_valid;
    logic        wrap;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] got_w[$];
    logic        got_r[$];

    always #5 clk = ~clk;

    waveform_generator #(.DATA_WIDTH(16), .ACC_WIDTH(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .fcw       (fcw),
        .fcw_load  (fcw_load),
        .phase_sync(phase_sync),
        .mode      (mode),
        .duty      (duty),
`ifdef WAVE_AMP_SCALE_EN
        .amp       (amp),
`endif
        .wave_out  (wave_out),
        .wave_valid(wave_valid),
        .wrap      (wrap)
    );

    always @(negedge clk) begin
        if (wave_valid) begin
            got_w.push_back(wave_out);
            got_r.push_back(wrap);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output for an unscaled sample f.
    function automatic logic [15:0] mdl(input logic [15:0] f);
`ifdef WAVE_AMP_SCALE_EN
        logic [31:0] p;
        p = 32'(f) * 32'(amp);
        return p[31:16];
`else
        return f;
`endif
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic flush();
        got_w.delete();
        got_r.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample_en  = 1'($urandom);
            fcw        = 24'($urandom);
            fcw_load   = 1'($urandom);
            phase_sync = 1'($urandom);
            mode       = 2'($urandom);
            duty       = 8'($urandom);
            step();
            chk($sformatf("rst_wave[%0d]", i), 32'(wave_out), 32'h0);
            chk($sformatf("rst_valid[%0d]", i), 32'(wave_valid), 32'h0);
            chk($sformatf("rst_wrap[%0d]", i), 32'(wrap), 32'h0);
        end
        rst_n = 1'b1;
        sample_en = 0; fcw = 0; fcw_load = 0; phase_sync = 0; mode = 0; duty = 0;
        step();
        flush();
    endtask

    task automatic load(input logic [23:0] w);
        fcw = w; fcw_load = 1'b1;
        step();
        fcw_load = 1'b0;
        step();
    endtask

    task automatic run(input int n);
        sample_en = 1'b1;
        repeat (n) step();
        sample_en = 1'b0;
        repeat (3) step();
    endtask

    logic [15:0] tri_tab [9] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF,
                                 16'hBFFF, 16'h7FFF, 16'h3FFF, 16'h0000};
    logic [15:0] e;

    initial begin
`ifdef WAVE_AMP_SCALE_EN
        amp = 16'hFFFF;
`endif
        rst_n = 0; sample_en = 0; fcw = 0; fcw_load = 0; phase_sync = 0; mode = 0; duty = 0;
        step();

        // reset values, first sample f(0) and latency
        do_reset();
        load(24'h100000);
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        chk("lat_cyc1", 32'(wave_valid), 32'(LAT == 1));
        step();
        chk("lat_cyc2", 32'(wave_valid), 32'(LAT == 2));
        chk("first_sample", 32'(wave_out), 32'(mdl(16'h0000)));
        step();
        chk("valid_pulse", 32'(wave_valid), 32'h0);
        step();

        // sawtooth
        do_reset();
        load(24'h100000);
        run(17);
        chk("saw_count", 32'(got_w.size()), 32'd17);
        for (int i = 0; i < 17; i++) begin
            e = (i < 16) ? 16'(i * 16'h1000) : 16'h0000;
            chk($sformatf("saw[%0d]", i), 32'(got_w[i]), 32'(mdl(e)));
            chk($sformatf("saw_wrap[%0d]", i), 32'(got_r[i]), 32'(i == 15));
        end

        // triangle
        do_reset();
        mode = 2'd1;
        load(24'h200000);
        run(9);
        chk("tri_count", 32'(got_w.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("tri[%0d]", i), 32'(got_w[i]), 32'(mdl(tri_tab[i])));
            chk($sformatf("tri_wrap[%0d]", i), 32'(got_r[i]), 32'(i == 7));
        end

        // deferred frequency change: load at acc=0x300000
        do_reset();
        load(24'h100000);
        sample_en = 1'b1;
        for (int i = 0; i < 19; i++) begin
            fcw_load = (i == 3);
            fcw      = 24'h200000;
            step();
        end
        sample_en = 1'b0; fcw_load = 1'b0;
        repeat (3) step();
        chk("defer_count", 32'(got_w.size()), 32'd19);
        for (int i = 0; i < 19; i++) begin
            e = (i < 16) ? 16'(i * 16'h1000) : 16'((i - 16) * 16'h2000);
            chk($sformatf("defer[%0d]", i), 32'(got_w[i]), 32'(mdl(e)));
            chk($sformatf("defer_wrap[%0d]", i), 32'(got_r[i]), 32'(i == 15));
        end

        // pulse duty 0x40, then duty 0
        do_reset();
        mode = 2'd3; duty = 8'h40;
        load(24'h100000);
        run(16);
        chk("pulse_count", 32'(got_w.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            e = (i < 4) ? 16'hFFFF : 16'h0000;
            chk($sformatf("pulse40[%0d]", i), 32'(got_w[i]), 32'(mdl(e)));
        end
        flush();
        duty = 8'h00;
        run(16);
        chk("pulse0_count", 32'(got_w.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("pulse0[%0d]", i), 32'(got_w[i]), 32'h0);

        // phase sync with simultaneous load
        do_reset();
`ifdef WAVE_AMP_SCALE_EN
        amp = 16'h8000;
`endif
        load(24'h100000);
        sample_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            phase_sync = (i == 5);
            fcw_load   = (i == 5);
            fcw        = 24'h200000;
            step();
        end
        sample_en = 1'b0; phase_sync = 1'b0; fcw_load = 1'b0;
        repeat (3) step();
        chk("sync_count", 32'(got_w.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            e = (i < 6) ? 16'(i * 16'h1000) : 16'((i - 6) * 16'h2000);
            chk($sformatf("sync[%0d]", i), 32'(got_w[i]), 32'(mdl(e)));
            chk($sformatf("sync_wrap[%0d]", i), 32'(got_r[i]), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
